codebreaker_led_out: RTL and testbench
======================================

Name: codebreaker_led_out

Overview:
Avalon-MM slave output port; the write-side counterpart of the codebreaker input PIOs.
- Nios II writes drive a registered `out_port` to board LEDs or indicator outputs.
- Adds atomic set/clear registers and a per-bit hardware blink engine, so software can flash the "guess wrong" and "code cracked" indicators without polling loops.
- Sits on the system interconnect next to the button and switch PIOs.

Parameters:
- WIDTH, 4, number of output bits (1..32).
- PERIOD_W, 24, width of the blink half-period counter (1..32).
- RESET_VALUE, 0, value of the DATA register after reset.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  reset; asynchronous, active-low.
- address  input  3  Avalon word address.
- chipselect  input  1  slave select.
- write_n  input  1  write strobe, active-low; write occurs when chipselect=1 and write_n=0.
- writedata  input  32  write data.
- readdata  output  32  registered read data.
- out_port  output  WIDTH  registered output to pins.

Behaviour:
- Reset (async, reset_n=0):
  - DATA=RESET_VALUE; MASK=0; PERIOD=0; cnt=0; phase=0.
  - readdata=0; out_port=RESET_VALUE.
- Address map, write side (WIDTH- or PERIOD_W-bit fields, upper writedata bits ignored):
  - 0 DATA: RW, DATA<=writedata[WIDTH-1:0].
  - 1 MASK: RW, blink-enable per bit.
  - 2 PERIOD: RW, blink half-period in clk cycles.
  - 3 STATUS: RO, bit0=phase, bits[PERIOD_W:1]=cnt; writes ignored.
  - 4 OUTSET: WO, DATA<=DATA | writedata[WIDTH-1:0]; reads 0.
  - 5 OUTCLEAR: WO, DATA<=DATA & ~writedata[WIDTH-1:0]; reads 0.
  - 6, 7: reserved; reads 0, writes ignored.
- Write timing: a write takes effect at the clock edge on which the strobe is sampled. The new register value is visible in the following cycle.
- Read timing:
  - readdata is registered on every clk edge from the address mux, regardless of chipselect. Read latency is 1 cycle.
  - Fields are zero-extended to 32 bits.
- Blink engine:
  - If PERIOD==0: cnt held 0, phase held 0.
  - Otherwise cnt increments each cycle. When cnt==PERIOD-1, cnt<=0 and phase toggles. Phase therefore toggles every PERIOD cycles (square wave with period 2*PERIOD).
  - PERIOD==1: phase toggles every cycle.
- Output: out_port <= DATA & ~(MASK & {WIDTH{phase}}), registered, one cycle after DATA/MASK/phase change. Blinking bits are on during phase 0 and off during phase 1.
- Boundary conditions:
  - Write to PERIOD (any value, including the same value): cnt<=0 and phase<=0 on the same edge. Gives a deterministic restart.
  - Software lowers PERIOD below the current cnt: cannot occur, because the PERIOD write already zeroes cnt.
  - cnt wraps only at PERIOD-1, never at 2^PERIOD_W. PERIOD=2^PERIOD_W-1 is the maximum half-period.
  - Write to MASK does not disturb cnt or phase.
  - MASK bit cleared while blinking: the bit follows DATA from the next out_port update.
  - Read of DATA in the cycle after an OUTSET write returns the updated value.
  - reset_n asserted mid-blink: all state is cleared immediately (async). After release, counting restarts from 0 only once PERIOD is rewritten, since PERIOD resets to 0.
- No wait states. No byteenable; 32-bit accesses only.

Decomposition:
- Shared package/header codebreaker_pio_pkg:
  - Address constants ADDR_DATA=0, ADDR_MASK=1, ADDR_PERIOD=2, ADDR_STATUS=3, ADDR_OUTSET=4, ADDR_OUTCLEAR=5.
  - Common to all codebreaker PIOs.
- One sub-module: codebreaker_blink_timer.
  - Parameter PERIOD_W.
  - Inputs clk, reset_n, period, restart.
  - Outputs phase, cnt.
  - Holds the counter/toggle logic.
- The top level holds the registers, the read mux and the output register.

Test Plan:
- Reset check: with RESET_VALUE=4'hA, hold reset_n low, then release -> out_port=4'hA, readdata=0; read addr 0 returns 0x0000000A one cycle after address is applied.
- Set/clear: write DATA=0x3, OUTSET=0xC, OUTCLEAR=0x5 -> out_port sequence 0x3, 0xF, 0xA, each change one cycle after its write; reads of addr 4/5 return 0.
- Blink: DATA=0xF, MASK=0x1, PERIOD=3 -> out_port bit0 low for 3 cycles, high for 3 cycles, repeating; bits[3:1] stay 1; STATUS cnt runs 0,1,2,0.
- Restart: mid-blink (phase=1, cnt=2), rewrite PERIOD=3 -> next STATUS read shows cnt=0, phase=0, and bit0 returns high one cycle later.
- PERIOD=0 / PERIOD=1: PERIOD=0 -> phase constant 0, out_port==DATA; PERIOD=1 -> bit0 toggles every cycle.
- Async reset mid-operation: assert reset_n between clock edges during blink -> out_port, readdata and STATUS go to reset values without waiting for clk; writes to addresses 6/7 never change any readable register.

Source files
------------

// File: rtl/codebreaker_pio_pkg.sv
// Shared definitions for the codebreaker Avalon-MM PIO family.
// Register word addresses and the bus write qualifier used by every PIO.
package codebreaker_pio_pkg;

   localparam int ADDR_W = 3;

   localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
   localparam logic [ADDR_W-1:0] ADDR_MASK     = 3'd1;
   localparam logic [ADDR_W-1:0] ADDR_PERIOD   = 3'd2;
   localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd3;
   localparam logic [ADDR_W-1:0] ADDR_OUTSET   = 3'd4;
   localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR = 3'd5;

   // Avalon write strobe: selected and write_n low.
   function automatic logic pio_write(input logic chipselect, input logic write_n);
      return chipselect & ~write_n;
   endfunction

endpackage

// File: rtl/codebreaker_blink_timer.sv
// Half-period counter and phase toggle for the LED blink engine.
// A zero period parks the timer; restart zeroes it on the same edge.
module codebreaker_blink_timer #(
   parameter int PERIOD_W = 24
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [PERIOD_W-1:0] period,
   input  logic                restart,
   output logic                phase,
   output logic [PERIOD_W-1:0] cnt
);

   localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic                phase_q, phase_d;
   logic                wrap;

   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      wrap    = (cnt_q == (period - ONE));
      if (restart || (period == '0)) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (wrap) begin
         // Wrap only at period-1, so the full counter range is usable.
         cnt_d   = '0;
         phase_d = ~phase_q;
      end else begin
         cnt_d = cnt_q + ONE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign phase = phase_q;
   assign cnt   = cnt_q;

endmodule

// File: rtl/codebreaker_led_out.sv
// Avalon-MM LED output port with atomic set/clear and per-bit blinking.
// Holds the DATA/MASK/PERIOD registers, the registered read mux and out_port.
module codebreaker_led_out
   import codebreaker_pio_pkg::*;
#(
   parameter int               WIDTH       = 4,
   parameter int               PERIOD_W    = 24,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [2:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [WIDTH-1:0]  out_port
);

   logic [WIDTH-1:0]    data_q, data_d;
   logic [WIDTH-1:0]    mask_q, mask_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [31:0]         readdata_q, readdata_d;
   logic [WIDTH-1:0]    out_q, out_d;

   logic                wr_en;
   logic                period_restart;
   logic [WIDTH-1:0]    wr_field;
   logic [PERIOD_W-1:0] wr_period;
   logic                blink_phase;
   logic [PERIOD_W-1:0] blink_cnt;
   logic [63:0]         status_wide;
   logic                unused_wdata;

   assign wr_en        = pio_write(chipselect, write_n);
   assign wr_field     = writedata[WIDTH-1:0];
   assign wr_period    = writedata[PERIOD_W-1:0];
   assign unused_wdata = ^writedata;

   always_comb begin
      data_d         = data_q;
      mask_d         = mask_q;
      period_d       = period_q;
      period_restart = 1'b0;
      if (wr_en) begin
         case (address)
            ADDR_DATA:     data_d = wr_field;
            ADDR_MASK:     mask_d = wr_field;
            ADDR_PERIOD: begin
               period_d       = wr_period;
               period_restart = 1'b1;
            end
            ADDR_OUTSET:   data_d = data_q | wr_field;
            ADDR_OUTCLEAR: data_d = data_q & ~wr_field;
            default: ;
         endcase
      end
   end

   codebreaker_blink_timer #(
      .PERIOD_W (PERIOD_W)
   ) u_blink_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .period  (period_q),
      .restart (period_restart),
      .phase   (blink_phase),
      .cnt     (blink_cnt)
   );

   // STATUS may exceed 32 bits when PERIOD_W is 32; the top cnt bit drops off.
   assign status_wide = 64'({blink_cnt, blink_phase});

   always_comb begin
      readdata_d = '0;
      case (address)
         ADDR_DATA:   readdata_d = 32'(data_q);
         ADDR_MASK:   readdata_d = 32'(mask_q);
         ADDR_PERIOD: readdata_d = 32'(period_q);
         ADDR_STATUS: readdata_d = status_wide[31:0];
         default:     readdata_d = '0;
      endcase
   end

   // Blinking bits are lit in phase 0 and dark in phase 1.
   always_comb begin
      out_d = data_q & ~(mask_q & {WIDTH{blink_phase}});
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q     <= RESET_VALUE;
         mask_q     <= '0;
         period_q   <= '0;
         readdata_q <= '0;
         out_q      <= RESET_VALUE;
      end else begin
         data_q     <= data_d;
         mask_q     <= mask_d;
         period_q   <= period_d;
         readdata_q <= readdata_d;
         out_q      <= out_d;
      end
   end

   assign readdata = readdata_q;
   assign out_port = out_q;

endmodule

// File: tb/tb_codebreaker_led_out.sv
// Self-checking bench for codebreaker_led_out: directed literal checks plus
// randomized bus traffic compared every cycle against a time-based model.
module tb_codebreaker_led_out;

   localparam int             W  = 4;
   localparam int             PW = 8;
   localparam logic [W-1:0]   RV = 4'hA;

   logic          clk        = 1'b0;
   logic          reset_n    = 1'b1;
   logic [2:0]    address    = 3'd7;
   logic          chipselect = 1'b0;
   logic          write_n    = 1'b1;
   logic [31:0]   writedata  = '0;
   logic [31:0]   readdata;
   logic [W-1:0]  out_port;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   codebreaker_led_out #(
      .WIDTH       (W),
      .PERIOD_W    (PW),
      .RESET_VALUE (RV)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: registers plus elapsed cycles since the last PERIOD write.
   logic [W-1:0]    m_data   = RV;
   logic [W-1:0]    m_mask   = '0;
   logic [PW-1:0]   m_period = '0;
   longint unsigned m_t      = 0;
   logic [31:0]     exp_rd   = '0;
   logic [W-1:0]    exp_out  = RV;

   function automatic logic m_phase();
      if (m_period == 0) return 1'b0;
      return ((m_t / m_period) % 2) == 1;
   endfunction

   function automatic logic [PW-1:0] m_cnt();
      if (m_period == 0) return '0;
      return PW'(m_t % m_period);
   endfunction

   initial begin : model
      logic          ph;
      logic [PW-1:0] cn;
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            m_data = RV; m_mask = '0; m_period = '0; m_t = 0;
            exp_rd = '0; exp_out = RV;
         end else begin
            ph = m_phase();
            cn = m_cnt();
            case (address)
               3'd0:    exp_rd = 32'(m_data);
               3'd1:    exp_rd = 32'(m_mask);
               3'd2:    exp_rd = 32'(m_period);
               3'd3:    exp_rd = 32'({cn, ph});
               default: exp_rd = '0;
            endcase
            exp_out = m_data & ~(m_mask & {W{ph}});
            m_t++;
            if (chipselect && !write_n) begin
               case (address)
                  3'd0: m_data = writedata[W-1:0];
                  3'd1: m_mask = writedata[W-1:0];
                  3'd2: begin m_period = writedata[PW-1:0]; m_t = 0; end
                  3'd4: m_data = m_data | writedata[W-1:0];
                  3'd5: m_data = m_data & ~writedata[W-1:0];
                  default: ;
               endcase
            end
         end
      end
   end

   initial begin : compare
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            chk("model_out_port", 32'(out_port), 32'(exp_out));
            chk("model_readdata", readdata, exp_rd);
         end
      end
   end

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
      $display("WR addr=%0d data=%h", a, d);
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      @(negedge clk);
      address = a;
      @(negedge clk);
      d = readdata;
      $display("RD addr=%0d data=%h", a, d);
   endtask

   logic [31:0] rv;
   logic [11:0] pat = 12'b111000111000;
   logic [31:0] st_exp [5] = '{32'd0, 32'd2, 32'd4, 32'd1, 32'd3};
   logic [W-1:0] out_exp [5] = '{4'hF, 4'hF, 4'hF, 4'hE, 4'hE};

   initial begin : stim
      #1 reset_n = 1'b0;
      cmp_en = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_out", 32'(out_port), 32'hA);
      chk("reset_rd", readdata, 32'h0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("release_rd", readdata, 32'h0);
      rd(3'd0, rv); chk("rd_data_reset", rv, 32'h0000000A);

      // Writes to STATUS and reserved addresses leave registers alone.
      wr(3'd6, 32'hFFFF_FFFF); wr(3'd7, 32'hFFFF_FFFF); wr(3'd3, 32'hFFFF_FFFF);
      rd(3'd0, rv); chk("rsv_data", rv, 32'hA);
      rd(3'd1, rv); chk("rsv_mask", rv, 32'h0);
      rd(3'd2, rv); chk("rsv_period", rv, 32'h0);
      rd(3'd3, rv); chk("rsv_status", rv, 32'h0);

      // Set / clear sequence.
      wr(3'd0, 32'h3); @(negedge clk); chk("sc_data", 32'(out_port), 32'h3);
      wr(3'd4, 32'hC); @(negedge clk); chk("sc_set", 32'(out_port), 32'hF);
      wr(3'd5, 32'h5); @(negedge clk); chk("sc_clear", 32'(out_port), 32'hA);
      rd(3'd4, rv); chk("rd_outset", rv, 32'h0);
      rd(3'd5, rv); chk("rd_outclear", rv, 32'h0);
      wr(3'd4, 32'h1);
      rd(3'd0, rv); chk("rd_after_set", rv, 32'hB);

      // Blink with PERIOD=3, STATUS walk, then restart at phase=1 cnt=2.
      wr(3'd0, 32'hF); wr(3'd1, 32'h1); wr(3'd2, 32'h3);
      address = 3'd3;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("blink_status", readdata, st_exp[i]);
         chk("blink_out", 32'(out_port), 32'(out_exp[i]));
      end
      address = 3'd2; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h3;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1; address = 3'd3;
      $display("WR addr=2 data=00000003 (restart)");
      chk("restart_rd_period", readdata, 32'h3);
      chk("restart_out_before", 32'(out_port), 32'hE);
      @(negedge clk);
      chk("restart_status", readdata, 32'h0);
      for (int i = 0; i < 12; i++) begin
         if (i > 0) @(negedge clk);
         chk("blink_pattern", 32'(out_port), pat[11-i] ? 32'hF : 32'hE);
      end

      // PERIOD=0 parks the engine; PERIOD=1 toggles every cycle.
      wr(3'd2, 32'h0);
      address = 3'd3;
      repeat (6) begin
         @(negedge clk);
         chk("p0_out", 32'(out_port), 32'hF);
         chk("p0_status", readdata, 32'h0);
      end
      wr(3'd2, 32'h1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("p1_out", 32'(out_port), (i % 2 == 0) ? 32'hF : 32'hE);
      end

      // Asynchronous reset between clock edges.
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("async_out", 32'(out_port), 32'hA);
      chk("async_rd", readdata, 32'h0);
      address = 3'd3;
      repeat (2) @(negedge clk);
      chk("async_status", readdata, 32'h0);
      reset_n = 1'b1;
      rd(3'd3, rv); chk("post_rst_status", rv, 32'h0);
      rd(3'd2, rv); chk("post_rst_period", rv, 32'h0);
      chk("post_rst_out", 32'(out_port), 32'hA);

      // Randomized traffic checked by the model every cycle.
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if ($urandom_range(0, 399) == 0) begin
            #2 reset_n = 1'b0;
            $display("RST async pulse");
            @(negedge clk);
            reset_n = 1'b1;
         end
         chipselect = ($urandom_range(0, 3) != 0);
         write_n    = $urandom_range(0, 1) == 1;
         address    = 3'($urandom_range(0, 7));
         writedata  = $urandom;
         if (address == 3'd2) begin
            writedata = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 255))
                                                    : 32'($urandom_range(0, 6));
            if ($urandom_range(0, 7) != 0) write_n = 1'b1;
         end
         if (chipselect && !write_n)
            $display("RWR addr=%0d data=%h", address, writedata);
      end
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
